// File: rtl/boot_copier_pkg.sv
// Shared definitions for the boot image copier: FSM encodings, Wishbone
// constants and the word-address helper used by the copy sequencer.
package boot_copier_pkg;

    // Copy sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR     = 3'd3,
        ST_WR_GAP = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } copy_state_t;

    // Single-access engine states
    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_STB  = 2'd1,
        ACC_GAP  = 2'd2
    } acc_state_t;

    localparam logic [3:0] WB_SEL_WORD   = 4'hF;
    localparam int         WB_WORD_SHIFT = 2;

    // Byte address of word 'index' above 'base'; wraps modulo 2^32
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] index);
        return base + (index << WB_WORD_SHIFT);
    endfunction

endpackage

// File: rtl/boot_copier_wb_single_access.sv
// One Wishbone classic access at a time. A request is accepted when idle or
// in the gap cycle; after an ack the strobe is always dropped for one gap
// cycle so edge-detecting slaves see a fresh strobe on the next access.
// The wait counter aborts an access that is not acknowledged in time.
module wb_single_access
    import boot_copier_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        go_we,
    input  logic [31:0] go_adr,
    input  logic [31:0] go_dat,
    output logic        fin,
    output logic        tout,
    output logic [31:0] rdata,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    localparam int             TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TLIM = TW'(TIMEOUT);

    acc_state_t    state;
    acc_state_t    state_next;
    logic [TW-1:0] tcnt;

    // Access state register
    always_ff @(posedge clk) begin
        if (rst) state <= ACC_IDLE;
        else     state <= state_next;
    end

    // Next access state; an ack on the last allowed cycle beats the timeout
    always_comb begin
        state_next = state;
        fin        = 1'b0;
        tout       = 1'b0;
        case (state)
            ACC_IDLE, ACC_GAP: state_next = go ? ACC_STB : ACC_IDLE;
            ACC_STB: begin
                if (wb_ack_i) begin
                    fin        = 1'b1;
                    state_next = ACC_GAP;
                end else if (tcnt == TLIM) begin
                    tout       = 1'b1;
                    state_next = ACC_IDLE;
                end
            end
            default: state_next = ACC_IDLE;
        endcase
    end

    // Registered bus drive and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            tcnt     <= '0;
        end else if (state != ACC_STB && go) begin
            wb_stb_o <= 1'b1;
            wb_we_o  <= go_we;
            wb_sel_o <= WB_SEL_WORD;
            wb_adr_o <= go_adr;
            wb_dat_o <= go_dat;
            tcnt     <= '0;
        end else if (state == ACC_STB) begin
            if (fin || tout) begin
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                wb_sel_o <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Read data capture on the acknowledged read
    always_ff @(posedge clk) begin
        if (state == ACC_STB && fin && !wb_we_o) rdata <= wb_dat_i;
    end

endmodule

// File: rtl/boot_copier.sv
// Boot image copier: reads WORDS words from SRC_BASE and writes them to
// DST_BASE over Wishbone, holding the CPU in reset until the copy is done.
module boot_copier
    import boot_copier_pkg::*;
#(
    parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
    parameter logic [31:0] DST_BASE   = 32'h0001_0000,
    parameter int          WORDS      = 4096,
    parameter int          TIMEOUT    = 255,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    localparam int            IW       = $clog2(WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS);

    copy_state_t   state;
    copy_state_t   state_next;
    logic [IW-1:0] idx;
    logic          armed;
    logic          restart;
    logic          go;
    logic          go_we;
    logic [31:0]   go_adr;
    logic [31:0]   go_dat;
    logic          fin;
    logic          tout;
    logic [31:0]   rdata;

    wb_single_access #(
        .TIMEOUT (TIMEOUT)
    ) u_access (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .go_we    (go_we),
        .go_adr   (go_adr),
        .go_dat   (go_dat),
        .fin      (fin),
        .tout     (tout),
        .rdata    (rdata),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i)
    );

    assign wb_cyc_o = wb_stb_o;
    assign cpu_hold = ~done;

    // Sequencer state register; 'armed' is high only on the first post-reset cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            armed <= AUTO_START;
        end else begin
            state <= state_next;
            armed <= 1'b0;
        end
    end

    // Sequencer next state: read, gap, write, gap per word
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start || armed) state_next = ST_RD;
            ST_RD:     if (fin) state_next = ST_RD_GAP; else if (tout) state_next = ST_ERR;
            ST_RD_GAP: state_next = ST_WR;
            ST_WR:     if (fin) state_next = ST_WR_GAP; else if (tout) state_next = ST_ERR;
            ST_WR_GAP: state_next = (idx == LAST_IDX) ? ST_DONE : ST_RD;
            ST_DONE,
            ST_ERR:    if (start) state_next = ST_RD;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Access request issued on the edge that enters RD or WR, so the strobe
    // rises together with the sequencer state; a fresh copy starts at word 0
    always_comb begin
        restart = (state_next == ST_RD) && (state != ST_WR_GAP) && (state != ST_RD);
        go      = 1'b0;
        go_we   = 1'b0;
        go_adr  = '0;
        go_dat  = '0;
        if (state_next == ST_RD && state != ST_RD) begin
            go     = 1'b1;
            go_adr = word_addr(SRC_BASE, restart ? 32'd0 : 32'(idx));
        end else if (state_next == ST_WR && state != ST_WR) begin
            go     = 1'b1;
            go_we  = 1'b1;
            go_adr = word_addr(DST_BASE, 32'(idx));
            go_dat = rdata;
        end
    end

    // Word index and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            busy <= state_next inside {ST_RD, ST_RD_GAP, ST_WR, ST_WR_GAP};
            if (restart) begin
                idx  <= '0;
                done <= 1'b0;
                err  <= 1'b0;
            end else begin
                if (state == ST_WR && fin) idx <= idx + 1'b1;
                if (state == ST_DONE) done <= 1'b1;
                if (state == ST_ERR)  err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boot_copier.sv
// Scoreboard bench for boot_copier: a ROM/RAM slave with programmable ack
// latency, an expected-transaction queue filled when each copy is launched,
// and a monitor that checks every acknowledged access and bus rules.
module tb_boot_copier;

    localparam logic [31:0] SRC = 32'hFFFF_FFF8;
    localparam logic [31:0] DST = 32'h0001_0000;
    localparam int          W   = 4;
    localparam int          TO  = 8;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xact_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err, cpu_hold;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]  wb_sel_o;
    logic        ack_r = 1'b0;
    logic        stray = 1'b0;
    logic        wb_ack;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc_cnt  = 0;
    int    lat      = 1;
    int    hold_rd  = -1;
    int    wait_cnt = 0;
    bit    mon_en   = 1'b0;
    bit    prev_acked = 1'b0;
    bit    prev_busy  = 1'b0;
    bit    prev_done  = 1'b0;
    int    t_start = 0;
    int    t_done  = 0;
    int    run = 0;
    int    last_run = 0;
    logic [31:0] rom [W];
    xact_t expq [$];
    xact_t mon_x;

    assign wb_ack = ack_r | stray;

    always #5 clk = ~clk;

    boot_copier #(
        .SRC_BASE   (SRC),
        .DST_BASE   (DST),
        .WORDS      (W),
        .TIMEOUT    (TO),
        .AUTO_START (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_ack_i (wb_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a - SRC) >> 2;
    endfunction

    // Slave: registered ack 'lat' cycles after strobe; ROM data for reads
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (wb_stb_o && !ack_r) begin
            if (!wb_we_o && hold_rd >= 0 && word_of(wb_adr_o) == 32'(hold_rd)) begin
                wait_cnt <= 0;
            end else if (wait_cnt + 1 >= lat) begin
                ack_r    <= 1'b1;
                wait_cnt <= 0;
                if (!wb_we_o)
                    wb_dat_i <= (word_of(wb_adr_o) < 32'(W)) ? rom[int'(word_of(wb_adr_o))] : 32'hDEAD_BEEF;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            ack_r    <= 1'b0;
            wait_cnt <= 0;
        end
    end

    // Monitor: bus rules every cycle, scoreboard on every acknowledged access
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
            chk("cpu_hold_eq_not_done", 32'(cpu_hold), 32'(!done));
            if (wb_stb_o) begin
                chk("sel_word", 32'(wb_sel_o), 32'hF);
                chk("adr_align", 32'(wb_adr_o[1:0]), 32'd0);
            end
            if (prev_acked) chk("gap_after_ack", 32'(wb_stb_o), 32'd0);
            if (wb_stb_o && wb_ack) begin
                chk("xact_pending", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    mon_x = expq.pop_front();
                    chk("xact_we", 32'(wb_we_o), 32'(mon_x.we));
                    chk("xact_adr", wb_adr_o, mon_x.adr);
                    if (mon_x.we) chk("xact_dat", wb_dat_o, mon_x.dat);
                end
            end
            if (busy && !prev_busy) t_start <= cyc_cnt;
            if (done && !prev_done) t_done  <= cyc_cnt;
            if (wb_stb_o) run <= run + 1;
            else if (run != 0) begin
                last_run <= run;
                run      <= 0;
            end
        end
        prev_acked <= wb_stb_o && wb_ack;
        prev_busy  <= busy;
        prev_done  <= done;
    end

    // Reference model: expected bus transactions of a copy, in order
    task automatic push_copy(input int nfull, input bit extra_read);
        xact_t x;
        for (int i = 0; i < nfull; i++) begin
            x.we = 1'b0; x.adr = SRC + 32'(4 * i); x.dat = '0;     expq.push_back(x);
            x.we = 1'b1; x.adr = DST + 32'(4 * i); x.dat = rom[i]; expq.push_back(x);
        end
        if (extra_read) begin
            x.we = 1'b0; x.adr = SRC + 32'(4 * nfull); x.dat = '0; expq.push_back(x);
        end
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < W; i++) rom[i] = $urandom;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done || err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("end_within_budget", 32'(done || err), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_stb"}, 32'(wb_stb_o), 32'd0);
        chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'd0);
        chk({tag, "_we"}, 32'(wb_we_o), 32'd0);
        chk({tag, "_sel"}, 32'(wb_sel_o), 32'd0);
        chk({tag, "_adr"}, wb_adr_o, 32'd0);
        chk({tag, "_dat"}, wb_dat_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    task automatic check_success(input string tag, input int l);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_cycles"}, 32'(t_done - t_start), 32'(2 * W * (l + 2) + 1));
        chk({tag, "_queue_drained"}, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // Power-on reset, then auto-started copy with fixed ROM pattern
        for (int i = 0; i < W; i++) rom[i] = 32'h1000_0000 + 32'(i);
        lat = 1;
        push_copy(W, 1'b0);
        repeat (3) @(negedge clk);
        check_reset("por");
        mon_en = 1'b1;
        rst    = 1'b0;
        wait_end(500);
        check_success("auto", lat);

        // Randomized copies with varying slave latency; one with start while busy
        for (int k = 0; k < 3; k++) begin
            lat = int'($urandom_range(1, 4));
            fill_rom_random();
            push_copy(W, 1'b0);
            pulse_start();
            if (k == 1) begin
                repeat (7) @(negedge clk);
                chk("busy_before_extra_start", 32'(busy), 32'd1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_end(500);
            check_success("rand", lat);
        end

        // Ack outside an access is ignored
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_done", 32'(done), 32'd1);
        chk("stray_stb", 32'(wb_stb_o), 32'd0);

        // Timeout on read 2, then a clean restart
        lat     = 1;
        hold_rd = 2;
        fill_rom_random();
        push_copy(2, 1'b0);
        pulse_start();
        wait_end(500);
        chk("to_err", 32'(err), 32'd1);
        chk("to_done", 32'(done), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("to_stb", 32'(wb_stb_o), 32'd0);
        chk("to_stb_cycles", 32'(last_run), 32'(TO + 1));
        chk("to_queue_drained", 32'(expq.size()), 32'd0);
        hold_rd = -1;
        fill_rom_random();
        push_copy(W, 1'b0);
        pulse_start();
        wait_end(500);
        check_success("after_to", lat);

        // Ack exactly on the last allowed cycle wins over the timeout
        lat = TO;
        fill_rom_random();
        push_copy(W, 1'b0);
        pulse_start();
        wait_end(1000);
        check_success("lat_eq_to", lat);

        // Reset during word 2 write, automatic restart from SRC_BASE
        lat = 1;
        fill_rom_random();
        push_copy(2, 1'b1);
        push_copy(W, 1'b0);
        pulse_start();
        n = 0;
        while (!(wb_stb_o && wb_we_o && wb_adr_o == DST + 32'd8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("saw_write2", 32'(wb_stb_o && wb_we_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        wait_end(500);
        check_success("after_rst", lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
